// File: rtl/id_stage_if.sv
// Bus between the IF/ID register, writeback, hazard unit and the decode stage.
interface id_stage_if #(
    parameter int unsigned XLEN = 32
);
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] PCPlus4;
    } ifid_t;

    ifid_t            inputs;
    logic             RegWriteW;
    logic [4:0]       RdW;
    logic [XLEN-1:0]  ResultW;
    logic             StallE;
    logic             FlushE;
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [XLEN-1:0]  RD1E;
    logic [XLEN-1:0]  RD2E;
    logic [XLEN-1:0]  ImmExtE;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  PCPlus4E;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             JumpE;
    logic             BranchE;
    logic [1:0]       ResultSrcE;
    logic             ALUSrcAE;
    logic             ALUSrcBE;
    logic [3:0]       ALUControlE;
    logic [2:0]       Funct3E;
    logic             IllegalE;

    modport master (
        output inputs, RegWriteW, RdW, ResultW, StallE, FlushE,
        input  Rs1D, Rs2D, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
        input  RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUSrcAE,
        input  ALUSrcBE, ALUControlE, Funct3E, IllegalE
    );

    modport slave (
        input  inputs, RegWriteW, RdW, ResultW, StallE, FlushE,
        output Rs1D, Rs2D, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE,
        output RegWriteE, MemWriteE, JumpE, BranchE, ResultSrcE, ALUSrcAE,
        output ALUSrcBE, ALUControlE, Funct3E, IllegalE
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register file, instruction decode, ID/EX pipeline register.
module id_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    id_stage_if.slave   bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam int unsigned NREGS = 32;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [1:0]      result_src;
        logic            alu_src_a;
        logic            alu_src_b;
        logic [3:0]      alu_ctrl;
        logic [2:0]      funct3;
        logic            illegal;
    } idex_t;

    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] instr;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [3:0]      alu_op;
    logic            wb_en;
    idex_t           idex_d;
    idex_t           idex_q;

    assign instr  = bus.inputs.instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign wb_en = bus.RegWriteW && (bus.RdW != 5'd0);

    // Register file storage; x0 is never written and is masked on read.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en) begin
            regs[bus.RdW] <= bus.ResultW;
        end
    end

    // Combinational reads with write-through from the writeback port.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != 5'd0) begin
            rd1 = (wb_en && bus.RdW == rs1) ? bus.ResultW : regs[rs1];
        end
        if (rs2 != 5'd0) begin
            rd2 = (wb_en && bus.RdW == rs2) ? bus.ResultW : regs[rs2];
        end
    end

    // ALU operation for OP / OP-IMM; SUB only exists in the register form.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000: alu_op = (opcode == OP_OP && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    // Main decoder: control signals, immediate select and legality check.
    always_comb begin
        idex_d          = '0;
        idex_d.rd1      = rd1;
        idex_d.rd2      = rd2;
        idex_d.pc       = bus.inputs.PC;
        idex_d.pc_plus4 = bus.inputs.PCPlus4;
        idex_d.rs1      = rs1;
        idex_d.rs2      = rs2;
        idex_d.rd       = rd;
        idex_d.funct3   = funct3;
        case (opcode)
            OP_LUI: begin
                idex_d.reg_write = 1'b1;
                idex_d.alu_src_b = 1'b1;
                idex_d.alu_ctrl  = ALU_PASSB;
                idex_d.imm       = imm_u;
            end
            OP_AUIPC: begin
                idex_d.reg_write = 1'b1;
                idex_d.alu_src_a = 1'b1;
                idex_d.alu_src_b = 1'b1;
                idex_d.imm       = imm_u;
            end
            OP_JAL: begin
                idex_d.reg_write  = 1'b1;
                idex_d.jump       = 1'b1;
                idex_d.result_src = 2'b10;
                idex_d.alu_src_a  = 1'b1;
                idex_d.alu_src_b  = 1'b1;
                idex_d.imm        = imm_j;
            end
            OP_JALR: begin
                idex_d.reg_write  = 1'b1;
                idex_d.jump       = 1'b1;
                idex_d.result_src = 2'b10;
                idex_d.alu_src_b  = 1'b1;
                idex_d.imm        = imm_i;
                idex_d.illegal    = (funct3 != 3'b000);
            end
            OP_BRANCH: begin
                idex_d.branch   = 1'b1;
                idex_d.alu_ctrl = ALU_SUB;
                idex_d.imm      = imm_b;
                idex_d.illegal  = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_LOAD: begin
                idex_d.reg_write  = 1'b1;
                idex_d.result_src = 2'b01;
                idex_d.alu_src_b  = 1'b1;
                idex_d.imm        = imm_i;
                idex_d.illegal    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            end
            OP_STORE: begin
                idex_d.mem_write = 1'b1;
                idex_d.alu_src_b = 1'b1;
                idex_d.imm       = imm_s;
                idex_d.illegal   = (funct3 > 3'b010);
            end
            OP_IMM: begin
                idex_d.reg_write = 1'b1;
                idex_d.alu_src_b = 1'b1;
                idex_d.alu_ctrl  = alu_op;
                idex_d.imm       = imm_i;
                if (funct3 == 3'b001) begin
                    idex_d.illegal = (funct7 != 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    idex_d.illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                end
            end
            OP_OP: begin
                idex_d.reg_write = 1'b1;
                idex_d.alu_ctrl  = alu_op;
                idex_d.illegal   = !((funct7 == 7'b0000000) ||
                                     (funct7 == 7'b0100000 &&
                                      (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            default: begin
                idex_d.illegal = 1'b1;
            end
        endcase
        if (idex_d.illegal) begin
            idex_d.reg_write  = 1'b0;
            idex_d.mem_write  = 1'b0;
            idex_d.jump       = 1'b0;
            idex_d.branch     = 1'b0;
            idex_d.result_src = 2'b00;
        end
    end

    // ID/EX register: reset, then flush (bubble), then stall (hold), then load.
    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            idex_q <= '0;
        end else if (!bus.StallE) begin
            idex_q <= idex_d;
        end
    end

    assign bus.Rs1D        = rs1;
    assign bus.Rs2D        = rs2;
    assign bus.RD1E        = idex_q.rd1;
    assign bus.RD2E        = idex_q.rd2;
    assign bus.ImmExtE     = idex_q.imm;
    assign bus.PCE         = idex_q.pc;
    assign bus.PCPlus4E    = idex_q.pc_plus4;
    assign bus.Rs1E        = idex_q.rs1;
    assign bus.Rs2E        = idex_q.rs2;
    assign bus.RdE         = idex_q.rd;
    assign bus.RegWriteE   = idex_q.reg_write;
    assign bus.MemWriteE   = idex_q.mem_write;
    assign bus.JumpE       = idex_q.jump;
    assign bus.BranchE     = idex_q.branch;
    assign bus.ResultSrcE  = idex_q.result_src;
    assign bus.ALUSrcAE    = idex_q.alu_src_a;
    assign bus.ALUSrcBE    = idex_q.alu_src_b;
    assign bus.ALUControlE = idex_q.alu_ctrl;
    assign bus.Funct3E     = idex_q.funct3;
    assign bus.IllegalE    = idex_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for the decode stage.
module tb_id_stage;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    id_stage_if #(.XLEN(32)) bus ();

    id_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        bus.inputs.instr   = instr;
        bus.inputs.PC      = pc;
        bus.inputs.PCPlus4 = pc + 32'd4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.RegWriteW = 1'b0; bus.RdW = 5'd0; bus.ResultW = '0;
        bus.StallE = 1'b0; bus.FlushE = 1'b0;
        drive(32'h00500093, 32'h0000_0100);
        step(); step();
        tests++; if (bus.RegWriteE !== 1'b0) begin fails++; $display("FAIL reset_regwrite got %0b want 0", bus.RegWriteE); end
        tests++; if (bus.ImmExtE !== 32'h0) begin fails++; $display("FAIL reset_imm got %h want 0", bus.ImmExtE); end
        tests++; if (bus.PCE !== 32'h0 || bus.RdE !== 5'd0) begin fails++; $display("FAIL reset_pc_rd got %h/%0d want 0/0", bus.PCE, bus.RdE); end
        drive(32'h00108133, 32'h0);
        #1;
        tests++; if (bus.Rs1D !== 5'd1 || bus.Rs2D !== 5'd1) begin fails++; $display("FAIL rsd_comb got %0d/%0d want 1/1", bus.Rs1D, bus.Rs2D); end
        reset = 1'b0;
    endtask

    task automatic test_addi();
        drive(32'h00500093, 32'h0000_0100);
        step();
        tests++; if (bus.RegWriteE !== 1'b1) begin fails++; $display("FAIL addi_regwrite got %0b want 1", bus.RegWriteE); end
        tests++; if (bus.RdE !== 5'd1) begin fails++; $display("FAIL addi_rd got %0d want 1", bus.RdE); end
        tests++; if (bus.ImmExtE !== 32'd5) begin fails++; $display("FAIL addi_imm got %h want 5", bus.ImmExtE); end
        tests++; if (bus.ALUSrcBE !== 1'b1 || bus.ALUControlE !== 4'b0000) begin fails++; $display("FAIL addi_alu got %0b/%b want 1/0000", bus.ALUSrcBE, bus.ALUControlE); end
        tests++; if (bus.IllegalE !== 1'b0) begin fails++; $display("FAIL addi_illegal got %0b want 0", bus.IllegalE); end
        tests++; if (bus.PCE !== 32'h100 || bus.PCPlus4E !== 32'h104) begin fails++; $display("FAIL addi_pc got %h/%h want 100/104", bus.PCE, bus.PCPlus4E); end
    endtask

    task automatic test_writethrough();
        bus.RegWriteW = 1'b1; bus.RdW = 5'd1; bus.ResultW = 32'hDEADBEEF;
        drive(32'h00108133, 32'h0000_0200);
        step();
        tests++; if (bus.RD1E !== 32'hDEADBEEF || bus.RD2E !== 32'hDEADBEEF) begin fails++; $display("FAIL wt_rd got %h/%h want deadbeef", bus.RD1E, bus.RD2E); end
        tests++; if (bus.ALUSrcBE !== 1'b0 || bus.RdE !== 5'd2) begin fails++; $display("FAIL wt_op got %0b/%0d want 0/2", bus.ALUSrcBE, bus.RdE); end
        bus.RegWriteW = 1'b0; bus.ResultW = 32'h0;
        step();
        tests++; if (bus.RD1E !== 32'hDEADBEEF) begin fails++; $display("FAIL rf_stored got %h want deadbeef", bus.RD1E); end
        bus.RegWriteW = 1'b1; bus.RdW = 5'd0; bus.ResultW = 32'h12345678;
        drive(32'h000001B3, 32'h0000_0204);
        step();
        tests++; if (bus.RD1E !== 32'h0 || bus.RD2E !== 32'h0) begin fails++; $display("FAIL x0_wt got %h/%h want 0", bus.RD1E, bus.RD2E); end
        bus.RegWriteW = 1'b0;
        step();
        tests++; if (bus.RD1E !== 32'h0) begin fails++; $display("FAIL x0_read got %h want 0", bus.RD1E); end
    endtask

    task automatic test_branch();
        drive(32'hFE000EE3, 32'h0000_0300);
        step();
        tests++; if (bus.ImmExtE !== 32'hFFFFFFFC) begin fails++; $display("FAIL beq_imm got %h want fffffffc", bus.ImmExtE); end
        tests++; if (bus.BranchE !== 1'b1 || bus.RegWriteE !== 1'b0 || bus.JumpE !== 1'b0) begin fails++; $display("FAIL beq_ctrl got b%0b w%0b j%0b want 1/0/0", bus.BranchE, bus.RegWriteE, bus.JumpE); end
        tests++; if (bus.ALUControlE !== 4'b0001 || bus.ALUSrcBE !== 1'b0) begin fails++; $display("FAIL beq_alu got %b/%0b want 0001/0", bus.ALUControlE, bus.ALUSrcBE); end
    endtask

    task automatic test_lui();
        drive(32'h123450B7, 32'h0000_0400);
        step();
        tests++; if (bus.ImmExtE !== 32'h12345000) begin fails++; $display("FAIL lui_imm got %h want 12345000", bus.ImmExtE); end
        tests++; if (bus.ALUControlE !== 4'b1010 || bus.ALUSrcAE !== 1'b0) begin fails++; $display("FAIL lui_alu got %b/%0b want 1010/0", bus.ALUControlE, bus.ALUSrcAE); end
    endtask

    task automatic test_other_classes();
        drive(32'h0020A423, 32'h0000_0500);
        step();
        tests++; if (bus.MemWriteE !== 1'b1 || bus.RegWriteE !== 1'b0) begin fails++; $display("FAIL sw_ctrl got m%0b w%0b want 1/0", bus.MemWriteE, bus.RegWriteE); end
        tests++; if (bus.ImmExtE !== 32'd8 || bus.Funct3E !== 3'b010) begin fails++; $display("FAIL sw_imm got %h/%b want 8/010", bus.ImmExtE, bus.Funct3E); end
        drive(32'h008000EF, 32'h0000_0600);
        step();
        tests++; if (bus.JumpE !== 1'b1 || bus.ResultSrcE !== 2'b10 || bus.ALUSrcAE !== 1'b1) begin fails++; $display("FAIL jal_ctrl got j%0b r%b a%0b want 1/10/1", bus.JumpE, bus.ResultSrcE, bus.ALUSrcAE); end
        tests++; if (bus.ImmExtE !== 32'd8) begin fails++; $display("FAIL jal_imm got %h want 8", bus.ImmExtE); end
        drive(32'h402081B3, 32'h0000_0700);
        step();
        tests++; if (bus.ALUControlE !== 4'b0001) begin fails++; $display("FAIL sub_alu got %b want 0001", bus.ALUControlE); end
        drive(32'h4020D1B3, 32'h0000_0704);
        step();
        tests++; if (bus.ALUControlE !== 4'b1001 || bus.IllegalE !== 1'b0) begin fails++; $display("FAIL sra_alu got %b/%0b want 1001/0", bus.ALUControlE, bus.IllegalE); end
        drive(32'h40109093, 32'h0000_0708);
        step();
        tests++; if (bus.IllegalE !== 1'b1 || bus.RegWriteE !== 1'b0) begin fails++; $display("FAIL slli_bad got i%0b w%0b want 1/0", bus.IllegalE, bus.RegWriteE); end
    endtask

    task automatic test_stall_flush();
        drive(32'h00500093, 32'h0000_0800);
        step();
        bus.StallE = 1'b1;
        drive(32'h123450B7, 32'h0000_0900);
        step(); step();
        tests++; if (bus.ImmExtE !== 32'd5 || bus.PCE !== 32'h800) begin fails++; $display("FAIL stall_hold got %h/%h want 5/800", bus.ImmExtE, bus.PCE); end
        tests++; if (bus.ALUControlE !== 4'b0000 || bus.RdE !== 5'd1 || bus.RegWriteE !== 1'b1) begin fails++; $display("FAIL stall_ctrl got %b/%0d/%0b want 0000/1/1", bus.ALUControlE, bus.RdE, bus.RegWriteE); end
        bus.FlushE = 1'b1;
        step();
        tests++; if (bus.RegWriteE !== 1'b0 || bus.ImmExtE !== 32'h0 || bus.PCE !== 32'h0 || bus.RdE !== 5'd0) begin fails++; $display("FAIL flush got w%0b %h %h %0d want all 0", bus.RegWriteE, bus.ImmExtE, bus.PCE, bus.RdE); end
        bus.StallE = 1'b0; bus.FlushE = 1'b0;
    endtask

    task automatic test_illegal();
        drive(32'hFFFFFFFF, 32'h0000_0A00);
        step();
        tests++; if (bus.IllegalE !== 1'b1) begin fails++; $display("FAIL illegal_flag got %0b want 1", bus.IllegalE); end
        tests++; if (bus.RegWriteE !== 1'b0 || bus.MemWriteE !== 1'b0) begin fails++; $display("FAIL illegal_en got w%0b m%0b want 0/0", bus.RegWriteE, bus.MemWriteE); end
    endtask

    task automatic test_reset_midstream();
        reset = 1'b1;
        drive(32'h00108133, 32'h0000_0B00);
        step();
        reset = 1'b0;
        tests++; if (bus.PCE !== 32'h0 || bus.IllegalE !== 1'b0) begin fails++; $display("FAIL midreset_e got %h/%0b want 0/0", bus.PCE, bus.IllegalE); end
        step();
        tests++; if (bus.RD1E !== 32'h0 || bus.PCE !== 32'hB00) begin fails++; $display("FAIL midreset_rf got %h/%h want 0/b00", bus.RD1E, bus.PCE); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_addi();
        test_writethrough();
        test_branch();
        test_lui();
        test_other_classes();
        test_stall_flush();
        test_illegal();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
